// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : instruction-fetch front end (req/ack to imem, valid/ready out)
// Rev 1.0
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemRdata,
  output logic [31:0] Instr,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        PCSrc,
  input  logic [31:0] BranchTarget,
  output logic [31:0] PC,
  output logic [31:0] PCPlus8
);

  localparam logic [31:0] c_word_step = 32'd4;
  localparam logic [31:0] c_r15_off   = 32'd8;

  typedef enum logic [0:0] {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_run;
  logic [31:0] r_fpc, w_fpc_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_valid, w_valid_nxt;
  logic        w_unused_tgt;

  // r_run keeps the request low during reset and the cycle reset is released,
  // so a stray ack in that window cannot be taken.
  assign ImemReq      = r_run && (r_state == S_REQ);
  assign ImemAddr     = r_fpc;
  assign Instr        = r_instr;
  assign InstrValid   = r_valid;
  assign PC           = r_pc;
  assign PCPlus8      = r_pc + c_r15_off;
  assign w_unused_tgt = ^BranchTarget[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_REQ;
      r_run   <= 1'b0;
      r_fpc   <= RESET_PC;
      r_instr <= 32'h0000_0000;
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= 1'b1;
      r_fpc   <= w_fpc_nxt;
      r_instr <= w_instr_nxt;
      r_pc    <= w_pc_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fpc_nxt   = r_fpc;
    w_instr_nxt = r_instr;
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_valid;
    case (r_state)
      S_REQ: begin
        if (ImemReq && ImemAck) begin
          w_instr_nxt = ImemRdata;
          w_pc_nxt    = r_fpc;
          w_valid_nxt = 1'b1;
          w_fpc_nxt   = r_fpc + c_word_step;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        // Redirect is only honoured on the retire cycle.
        if (InstrReady) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_REQ;
          if (PCSrc) w_fpc_nxt = {BranchTarget[31:2], 2'b00};
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end that produces the 32-bit instruction word and its PC for the single-cycle ARM controller/datapath.
- Owns the fetch PC and runs a req/ack handshake with instruction memory.
- Presents one instruction at a time to the consumer under a valid/ready handshake.
- Applies the consumer's branch redirect (PCSrc + target) when an instruction retires.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 00.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ImemReq  out  1  read request to instruction memory.
- ImemAddr  out  32  word-aligned fetch address; valid while ImemReq=1.
- ImemAck  in  1  memory response; ImemRdata is valid in the same cycle.
- ImemRdata  in  32  fetched instruction word.
- Instr  out  32  registered instruction presented to the controller/datapath.
- InstrValid  out  1  Instr and PC hold a valid instruction.
- InstrReady  in  1  consumer retires the instruction this cycle.
- PCSrc  in  1  taken branch or PC write for the retiring instruction.
- BranchTarget  in  32  redirect address; bits [1:0] ignored.
- PC  out  32  address of Instr.
- PCPlus8  out  32  PC+8, combinational (R15 read value).

Behaviour:
- Reset (async, immediate):
  - state=REQ; fpc=RESET_PC.
  - Instr=0, InstrValid=0, PC=RESET_PC.
  - ImemReq=0 while reset is asserted; ImemAddr=RESET_PC.
- State machine, two states:
  - REQ: ImemReq=1, ImemAddr=fpc.
    - ImemAck=0: stay in REQ; ImemAddr held stable.
    - ImemAck=1: Instr<=ImemRdata, PC<=fpc, InstrValid<=1, fpc<=fpc+4, go to HOLD.
  - HOLD: ImemReq=0, InstrValid=1; Instr and PC held.
    - InstrReady=0: stay in HOLD; PCSrc ignored.
    - InstrReady=1 (retire): InstrValid<=0, go to REQ.
    - If PCSrc=1 at retire: fpc<={BranchTarget[31:2],2'b00}; otherwise fpc keeps its sequential value.
- Timing:
  - ImemReq rises in the first clock edge after reset deasserts.
  - Latency from ImemAck to InstrValid is 1 cycle.
  - Zero-wait memory gives 1 instruction per 2 cycles (REQ, HOLD); each extra wait cycle adds 1 cycle.
- Arithmetic:
  - fpc+4 and PC+8 wrap modulo 2^32: fpc 32'hFFFF_FFFC -> 32'h0000_0000; PC 32'hFFFF_FFFC gives PCPlus8 32'h0000_0004.
- Protocol rules:
  - ImemAck while ImemReq=0 is ignored; no state change.
  - PCSrc and BranchTarget are sampled only on a retire cycle (InstrValid & InstrReady).
  - InstrReady while InstrValid=0 has no effect.
- Boundary and simultaneous events:
  - Redirect to the same address as the sequential fpc behaves identically to no redirect.
  - Redirect to the current PC (self-loop) refetches that address.
- Reset mid-operation (any state, including ImemReq high):
  - Returns to reset values immediately.
  - Any ImemAck arriving while reset is high or in the cycle reset deasserts (ImemReq=0) is discarded.

Test Plan:
- Reset RESET_PC=0, memory acks in the same cycle as req returning 32'hE3A0_1005 -> ImemAddr=0; next cycle Instr=E3A01005, PC=0, PCPlus8=8, InstrValid=1.
- Hold InstrReady=0 for 5 cycles, then pulse it -> Instr/PC stable and ImemReq=0 throughout; next ImemAddr=4.
- Memory inserts 3 wait cycles -> ImemReq held 4 cycles with ImemAddr constant; InstrValid rises 1 cycle after ack.
- Retire PC=8 with PCSrc=1, BranchTarget=32'h0000_0103 -> next ImemAddr=32'h0000_0100; following fetch goes to 0x104.
- PCSrc=1 while InstrValid=0, and ImemAck with ImemReq=0 -> no effect on fpc or state.
- Assert reset while in REQ with fpc=0x40 -> ImemReq drops immediately; after release ImemAddr=RESET_PC. Separately, fetch at 32'hFFFF_FFFC -> next ImemAddr=0.
